// File: rtl/csa_multibyte_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : csa_multibyte_seq_if
// Description : Request/result handshake bundle for the byte-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface csa_multibyte_seq_if #(
   parameter int NBYTES = 4
);
   localparam int c_width = 8 * NBYTES;

   logic               start_valid;
   logic               start_ready;
   logic [c_width-1:0] a_in;
   logic [c_width-1:0] b_in;
   logic               c_in;
   logic               sub;
   logic               result_valid;
   logic               result_ready;
   logic [c_width-1:0] sum;
   logic               c_out;
   logic               busy;

   modport master (
      output start_valid, a_in, b_in, c_in, sub, result_ready,
      input  start_ready, result_valid, sum, c_out, busy
   );

   modport slave (
      input  start_valid, a_in, b_in, c_in, sub, result_ready,
      output start_ready, result_valid, sum, c_out, busy
   );
endinterface
`default_nettype wire

// File: rtl/csa_multibyte_seq.sv
`default_nettype none
// ============================================================================
// Module      : csa_multibyte_seq
// Description : Byte-serial add/subtract through one 8-bit carry-select slice.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_multibyte_seq #(
   parameter int NBYTES = 4
) (
   input logic                clk,
   input logic                reset,
   csa_multibyte_seq_if.slave bus
);
   localparam int c_width = 8 * NBYTES;
   localparam int c_cnt_w = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NBYTES - 1);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_run  = 2'd1;
   localparam logic [1:0] c_done = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_next_state;
   logic [c_width-1:0] r_a;
   logic [c_width-1:0] r_b;
   logic [c_width-1:0] r_sum;
   logic               r_c_out;
   logic               r_carry;
   logic [c_cnt_w-1:0] r_cnt;

   logic               w_start_ready;
   logic               w_result_valid;
   logic               w_busy;
   logic               w_accept;
   logic               w_last;
   logic [7:0]         w_byte_a;
   logic [7:0]         w_byte_b;
   logic [4:0]         w_lo;
   logic [3:0]         w_hi0;
   logic [3:0]         w_hi1;
   logic [7:0]         w_s;
   logic               w_carry_next;

   assign w_accept = bus.start_valid && w_start_ready;
   assign w_last   = (r_cnt == c_last);
   assign w_byte_a = r_a[{r_cnt, 3'b000} +: 8];
   assign w_byte_b = r_b[{r_cnt, 3'b000} +: 8];

   // Carry-select slice: low nibble ripples, both high-nibble sums are ready in parallel.
   assign w_lo  = {1'b0, w_byte_a[3:0]} + {1'b0, w_byte_b[3:0]} + {4'b0000, r_carry};
   assign w_hi0 = w_byte_a[7:4] + w_byte_b[7:4];
   assign w_hi1 = w_byte_a[7:4] + w_byte_b[7:4] + 4'd1;
   assign w_s   = {(w_lo[4] ? w_hi1 : w_hi0), w_lo[3:0]};

   // The slice has no carry-out; recover it from the MSB operands and sum bit.
   assign w_carry_next = (w_byte_a[7] & w_byte_b[7]) |
                         ((w_byte_a[7] ^ w_byte_b[7]) & ~w_s[7]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_idle:  if (w_accept) w_next_state = c_run;
         c_run:   if (w_last) w_next_state = c_done;
         c_done:  if (bus.result_ready) w_next_state = bus.start_valid ? c_run : c_idle;
         default: w_next_state = c_idle;
      endcase
   end

   always_comb begin
      w_start_ready  = 1'b0;
      w_result_valid = 1'b0;
      w_busy         = 1'b1;
      case (r_state)
         c_idle: begin
            w_start_ready = 1'b1;
            w_busy        = 1'b0;
         end
         c_done: begin
            w_start_ready  = bus.result_ready;
            w_result_valid = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_c_out <= 1'b0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_a     <= bus.a_in;
         r_b     <= bus.sub ? ~bus.b_in : bus.b_in;
         r_carry <= bus.sub | bus.c_in;
         r_cnt   <= '0;
      end else if (r_state == c_run) begin
         r_sum[{r_cnt, 3'b000} +: 8] <= w_s;
         r_carry                     <= w_carry_next;
         if (w_last) begin
            r_c_out <= w_carry_next;
         end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
         end
      end
   end

   assign bus.start_ready  = w_start_ready;
   assign bus.result_valid = w_result_valid;
   assign bus.busy         = w_busy;
   assign bus.sum          = r_sum;
   assign bus.c_out        = r_c_out;
endmodule
`default_nettype wire
